clapton_deser: RTL and testbench
================================

Name: clapton_deser

Overview:
- Serial receiver for the 1-bit Y stream produced by the eric_clapton datapath.
- Frames the stream (start / data / stop), reassembles DATA_W-bit words LSB-first and buffers them in a small FIFO.
- Presents words downstream on a valid/ready interface.
- Sits between the serial line and the nibble-consuming logic that feeds the A/B/C operand registers.

Parameters:
- DATA_W, 4, data bits per frame (1..8).
- FIFO_DEPTH, 2, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  serial line; idles at 1.
- din_en  in  1  sample strobe; din is consumed only in cycles where din_en=1.
- dout  out  DATA_W  head-of-FIFO word.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts dout this cycle when dout_valid=1.
- frame_err  out  1  one-cycle pulse on a bad stop (or parity) bit.
- overflow  out  1  sticky; a completed frame was dropped because the FIFO was full.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async): state=IDLE, bit counter=0, shift register=0, FIFO empty.
- Outputs during reset: dout=0, dout_valid=0, frame_err=0, overflow=0, fill=0.
- Reset mid-frame discards the partial word and all buffered words.
- No action in any state while din_en=0; counters and state hold.
- IDLE: din_en & din=0 -> DATA, counter=0. din=1 stays IDLE.
- DATA: on each din_en, shreg[counter]<=din, counter++. After bit DATA_W-1 is sampled -> STOP (or PARITY, see Optional Feature).
- STOP, din_en & din=1:
  - Push shreg if FIFO not full, or if full and dout_valid&dout_ready in the same cycle (simultaneous push+pop allowed when full).
  - Otherwise drop the word and set overflow=1.
  - Go to IDLE.
- STOP, din_en & din=0:
  - frame_err=1 for exactly that cycle; word dropped; -> IDLE.
  - This 0 is NOT treated as a new start bit.
- Latency: a pushed word is visible on dout/dout_valid in the cycle after the stop-bit sampling edge.
- FIFO pop occurs when dout_valid & dout_ready. dout_ready while empty is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- fill updates one cycle after the push/pop edge: +1 push only, -1 pop only, unchanged on both.
- dout is held stable while dout_valid=1 and dout_ready=0.
- overflow is cleared only by reset.
- Back-to-back frames: a start bit sampled on the first din_en after STOP is accepted (no idle gap required).

Optional Feature:
- Macro CLAPTON_DESER_PARITY_EN.
- Defined:
  - Extra state PARITY between DATA and STOP; one bit sampled there.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Mismatch -> frame_err pulse at the STOP sample and the word is dropped, even if stop=1.
  - A bad stop bit produces a single frame_err pulse.
- Undefined:
  - No PARITY state; frame = 1 start + DATA_W data + 1 stop bits.
  - Parity logic is absent from the netlist.

Decomposition:
- Package clapton_pkg:
  - State enum (IDLE, DATA, PARITY, STOP).
  - Default DATA_W constant and the IDLE_LEVEL=1 constant.
- Sub-module clapton_fifo holds storage, pointers and the fill count.
  - Ports: clk, reset, push, wdata, pop, rdata, empty, full, fill.
- The top module keeps the framing FSM and shift register only.

Test Plan:
- Reset checks:
  - Hold reset=0 with din=0 and din_en=1 -> all outputs 0.
  - Release reset; line idle at 1 for 5 cycles -> dout_valid stays 0.
- Single frame, DATA_W=4, dout_ready=0, din_en=1 every cycle: din sequence 0,1,0,1,1,1 (start, data LSB-first 1,0,1,1, stop).
  - The cycle after the stop edge -> dout=4'b1101, dout_valid=1, fill=1.
  - Then raise dout_ready -> dout_valid=0 on the next cycle.
- Framing error: 0,0,0,1,1,0 (bad stop).
  - frame_err pulses exactly one cycle; no push; state returns to IDLE.
  - A following 0,1,1,1,1,1 yields dout=4'hF.
- Overflow: three frames 4'h3, 4'h9, 4'h6 with dout_ready=0 and FIFO_DEPTH=2.
  - fill=2, overflow=1.
  - Popping returns 3 then 9.
- din_en gating: same frame as the single-frame test, with din_en=0 for 3 cycles between every bit (din toggled randomly while din_en=0) -> dout=4'b1101.
- Mid-frame reset and full push+pop:
  - Assert reset after 2 data bits -> FIFO empty; the next full frame decodes correctly.
  - With the FIFO full and dout_ready=1 on the stop cycle -> no overflow, fill stays 2.

Source files
------------

// File: rtl/clapton_pkg.sv
// Shared types and constants for the clapton serial receiver.
// The optional PARITY state is only entered when CLAPTON_DESER_PARITY_EN is defined.
package clapton_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int   DEFAULT_DATA_W = 4;
  // Level of the idle line, which is also the level of a good stop bit.
  localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/clapton_fifo.sv
// Small output FIFO for deserialized words: power-of-two depth and wrapping pointers.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module clapton_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_q, pop_q;

  assign empty  = (fill == '0);
  assign full   = (fill == (AW+1)'(DEPTH));
  assign pop_q  = pop & ~empty;
  assign push_q = push & (~full | pop_q);
  assign rdata  = mem[rptr];

  // Storage and pointers. A reset clears the storage so that dout reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_q) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop_q) rptr <= rptr + 1'b1;
    end
  end

  // Occupancy: +1 on push only, -1 on pop only, unchanged when both happen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else begin
      case ({push_q, pop_q})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/clapton_deser.sv
// Serial receiver for the Y stream. It frames start/data/stop, rebuilds LSB-first
// words and buffers them for a valid/ready consumer.
// Optional even parity bit: define CLAPTON_DESER_PARITY_EN.
module clapton_deser
  import clapton_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          din,
  input  logic                          din_en,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              empty, full, pop, push, par_ok, stop_ok;

`ifdef CLAPTON_DESER_PARITY_EN
  logic par_bit;
  // Even parity: the data bits and the parity bit must XOR to zero.
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok = 1'b1;
`endif

  assign dout_valid = ~empty;
  assign pop        = dout_ready & ~empty;
  assign stop_ok    = din_en & (state == STOP) & (din == IDLE_LEVEL) & par_ok;
  // A full FIFO still takes the word when the consumer pops in the same cycle.
  assign push       = stop_ok & (~full | pop);

  // Framing FSM and shift register. Every transition is gated by din_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef CLAPTON_DESER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (din_en) begin
        case (state)
          IDLE: begin
            if (din != IDLE_LEVEL) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg[cnt] <= din;
            cnt        <= cnt + 1'b1;
            if (cnt == CW'(DATA_W-1)) begin
              cnt <= '0;
`ifdef CLAPTON_DESER_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef CLAPTON_DESER_PARITY_EN
          PARITY: begin
            par_bit <= din;
            state   <= STOP;
          end
`endif
          STOP: begin
            // A low stop bit is a framing error and is not taken as a new start bit.
            if (din != IDLE_LEVEL || !par_ok) frame_err <= 1'b1;
            else if (!(~full | pop))          overflow  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  clapton_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (dout),
    .empty (empty),
    .full  (full),
    .fill  (fill)
  );

endmodule

// File: tb/tb_clapton_deser.sv
// Randomized self-checking bench for clapton_deser. It compares the DUT against a
// frame-level model that keeps expected words in a queue.
module tb_clapton_deser;
  localparam int DW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          din = 1'b1, din_en = 1'b0, dout_ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, frame_err, overflow;
  logic [1:0]    fill;

  int unsigned   npass = 0, ntotal = 0;
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;

  clapton_deser #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din(din), .din_en(din_en), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_err(frame_err),
    .overflow(overflow), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    din = 1'b1; din_en = 1'b0; dout_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    q.delete(); m_ovf = 1'b0;
    @(negedge clk);
  endtask

  // Sends one frame, updates the model at the stop bit and checks status afterwards.
  task automatic send_frame(input logic [DW-1:0] w, input bit stop, input int gaps, input bit rdy_stop);
    logic bits[$];
    bit   popped;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
`ifdef CLAPTON_DESER_PARITY_EN
    bits.push_back(^w);
`endif
    bits.push_back(stop);
    popped = 1'b0;
    for (int k = 0; k < bits.size(); k++) begin
      din = bits[k]; din_en = 1'b1;
      if (k == bits.size()-1) begin
        dout_ready = rdy_stop;
        if (rdy_stop && q.size() > 0) begin
          ntotal++;
          if (dout !== q[0]) $display("FAIL stop_pop_dout got=%h exp=%h", dout, q[0]);
          else npass++;
          popped = 1'b1;
        end
      end
      @(negedge clk);
      dout_ready = 1'b0; din_en = 1'b0;
      if (k < bits.size()-1)
        for (int g = 0; g < gaps; g++) begin din = 1'($urandom); @(negedge clk); end
    end
    din = 1'b1;
    if (popped) void'(q.pop_front());
    if (stop) begin
      if (q.size() < DEPTH) q.push_back(w);
      else m_ovf = 1'b1;
    end
    ntotal++;
    if (frame_err !== !stop) $display("FAIL frame_err got=%b exp=%b", frame_err, !stop);
    else npass++;
    ntotal++;
    if ({dout_valid, fill, overflow} !== {q.size() != 0, 2'(q.size()), m_ovf})
      $display("FAIL status valid/fill/ovf got=%b_%0d_%b exp=%b_%0d_%b",
               dout_valid, fill, overflow, q.size() != 0, q.size(), m_ovf);
    else npass++;
    if (q.size() > 0) begin
      ntotal++;
      if (dout !== q[0]) $display("FAIL head_dout got=%h exp=%h", dout, q[0]);
      else npass++;
    end
  endtask

  // Pops one word if any is buffered; a ready while empty must change nothing.
  task automatic pop_one();
    if (q.size() > 0) begin
      ntotal++;
      if (dout !== q[0] || dout_valid !== 1'b1)
        $display("FAIL pop_dout got=%h/%b exp=%h/1", dout, dout_valid, q[0]);
      else npass++;
      void'(q.pop_front());
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    ntotal++;
    if ({dout_valid, fill} !== {q.size() != 0, 2'(q.size())})
      $display("FAIL after_pop got=%b_%0d exp=%b_%0d", dout_valid, fill, q.size() != 0, q.size());
    else npass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; din = 1'b0; din_en = 1'b1; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    ntotal++;
    if ({dout, dout_valid, frame_err, overflow, fill} !== '0)
      $display("FAIL reset_outputs got=%h_%b_%b_%b_%0d exp=all0", dout, dout_valid, frame_err, overflow, fill);
    else npass++;
    din = 1'b1; din_en = 1'b1; dout_ready = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ntotal++;
      if (dout_valid !== 1'b0) $display("FAIL idle_valid cycle=%0d got=%b exp=0", i, dout_valid);
      else npass++;
    end
    din_en = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    send_frame(4'b1101, 1'b1, 0, 1'b0);
    pop_one();
  endtask

  task automatic test_frame_err();
    do_reset();
    send_frame(4'b1100, 1'b0, 0, 1'b0);
    @(negedge clk);
    ntotal++;
    if (frame_err !== 1'b0) $display("FAIL frame_err_width got=%b exp=0", frame_err);
    else npass++;
    send_frame(4'hF, 1'b1, 0, 1'b0);
    pop_one();
  endtask

  task automatic test_overflow();
    do_reset();
    send_frame(4'h3, 1'b1, 0, 1'b0);
    send_frame(4'h9, 1'b1, 0, 1'b0);
    send_frame(4'h6, 1'b1, 0, 1'b0);
    pop_one();
    pop_one();
    ntotal++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky got=%b exp=1", overflow);
    else npass++;
  endtask

  task automatic test_gating();
    do_reset();
    send_frame(4'b1101, 1'b1, 3, 1'b0);
    pop_one();
  endtask

  task automatic test_midreset();
    do_reset();
    send_frame(4'hA, 1'b1, 0, 1'b0);
    // Start bit plus two data bits, then reset.
    din_en = 1'b1;
    din = 1'b0; @(negedge clk);
    din = 1'b1; @(negedge clk);
    din = 1'b0; @(negedge clk);
    din_en = 1'b0;
    do_reset();
    ntotal++;
    if ({dout_valid, fill} !== 3'b000) $display("FAIL midreset_empty got=%b_%0d exp=0_0", dout_valid, fill);
    else npass++;
    send_frame(4'h5, 1'b1, 0, 1'b0);
    pop_one();
  endtask

  task automatic test_full_pushpop();
    do_reset();
    send_frame(4'h1, 1'b1, 0, 1'b0);
    send_frame(4'h2, 1'b1, 0, 1'b0);
    send_frame(4'hC, 1'b1, 0, 1'b1);
    pop_one();
    pop_one();
    pop_one();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 30; n++) begin
      send_frame(DW'($urandom), ($urandom % 5) != 0, $urandom % 3, 1'($urandom));
      if ($urandom % 2) pop_one();
    end
    while (q.size() > 0) pop_one();
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_overflow();
    test_gating();
    test_midreset();
    test_full_pushpop();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
